// File: rtl/car_pkg.sv
// Shared codes for the line-follower motor controller: motion states, tracker
// decisions, H-bridge direction encodings and turn memory.
package car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_LEFT   = 3'd2,
    ST_RIGHT  = 3'd3,
    ST_STOP   = 3'd4,
    ST_SEARCH = 3'd5
  } motion_t;

  localparam logic [1:0] TRK_STRAIGHT = 2'b11;
  localparam logic [1:0] TRK_LEFT     = 2'b10;
  localparam logic [1:0] TRK_RIGHT    = 2'b01;
  localparam logic [1:0] TRK_STOP     = 2'b00;

  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_BRK = 2'b00;

  localparam logic TURN_LEFT  = 1'b0;
  localparam logic TURN_RIGHT = 1'b1;

  localparam logic [2:0] SENSOR_ALL_OFF = 3'b111;

endpackage

// File: rtl/motor_drive_ctrl_pwm_channel.sv
// One wheel output stage: period-aligned duty/direction register plus PWM compare.
// SOFT_START_EN selects the ramped update in place of a direct load.
module pwm_channel
  import car_pkg::*;
#(
  parameter int CW        = 10,
  parameter int RAMP_STEP = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_strobe,
  input  logic            i_kill,
  input  logic [CW:0]     i_target_duty,
  input  logic [1:0]      i_target_dir,
  input  logic [CW-1:0]   i_cnt,
  output logic            o_pwm,
  output logic [1:0]      o_dir
);

  logic [CW:0] r_duty;
  logic [1:0]  r_dir;

`ifdef SOFT_START_EN
  localparam logic [CW:0] STEP = (CW+1)'(RAMP_STEP);

  logic [CW:0] w_step;
  logic [CW:0] w_down;
  logic [CW:0] w_up0;

  always_comb begin
    w_step = r_duty;
    if (i_target_duty > r_duty)
      w_step = (i_target_duty - r_duty > STEP) ? r_duty + STEP : i_target_duty;
    else if (i_target_duty < r_duty)
      w_step = (r_duty - i_target_duty > STEP) ? r_duty - STEP : i_target_duty;
    w_down = (r_duty > STEP) ? r_duty - STEP : '0;
    w_up0  = (i_target_duty > STEP) ? STEP : i_target_duty;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || i_kill) begin
      r_duty <= '0;
      r_dir  <= DIR_BRK;
    end else if (i_strobe) begin
`ifdef SOFT_START_EN
      // A direction reversal waits until the wheel has ramped down to zero.
      if (r_dir != i_target_dir) begin
        if (r_duty == '0) begin
          r_dir  <= i_target_dir;
          r_duty <= w_up0;
        end else begin
          r_duty <= w_down;
        end
      end else begin
        r_duty <= w_step;
      end
`else
      r_duty <= i_target_duty;
      r_dir  <= i_target_dir;
`endif
    end
  end

  assign o_pwm = ({1'b0, i_cnt} < r_duty);
  assign o_dir = r_dir;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Motion sequencer for the two-wheel car: debounces the tracker decision, runs the
// motion FSM with lost-line search, drives both PWM channels. Option: SOFT_START_EN.
module motor_drive_ctrl
  import car_pkg::*;
#(
  parameter int PWM_PERIOD   = 1024,
  parameter int DUTY_FAST    = 1000,
  parameter int DUTY_SLOW    = 600,
  parameter int DEBOUNCE     = 4,
  parameter int LOST_TIMEOUT = 1 << 20,
  parameter int RAMP_STEP    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_move,
  input  logic [1:0] track_state,
  input  logic [2:0] sensor,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [1:0] left_dir,
  output logic [1:0] right_dir,
  output logic [2:0] motion,
  output logic       lost
);

  localparam int CW = $clog2(PWM_PERIOD);
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int LCW = $clog2(LOST_TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [CW:0]    D_FAST   = (CW+1)'(DUTY_FAST);
  localparam logic [CW:0]    D_SLOW   = (CW+1)'(DUTY_SLOW);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE - 1);
  localparam logic [DBW-1:0] DB_FULL  = DBW'(DEBOUNCE);
  localparam logic [LCW-1:0] LOST_MAX = LCW'(LOST_TIMEOUT - 1);

  motion_t        r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_cand, r_filt;
  logic [DBW-1:0] r_db_cnt;
  logic [LCW-1:0] r_lost_cnt;
  logic           r_last_turn;
  logic           w_strobe, w_off_line;
  logic [CW:0]    w_l_duty, w_r_duty;
  logic [1:0]     w_l_dir, w_r_dir;

  assign w_strobe   = (r_cnt == CNT_LAST);
  assign w_off_line = (sensor == SENSOR_ALL_OFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_cand      <= TRK_STRAIGHT;
      r_filt      <= TRK_STRAIGHT;
      r_db_cnt    <= '0;
      r_lost_cnt  <= '0;
      r_last_turn <= TURN_LEFT;
      r_state     <= ST_IDLE;
    end else begin
      r_cnt   <= w_strobe ? '0 : r_cnt + 1'b1;
      r_state <= w_next;
      // A changed sample counts as the first of the new run.
      if (track_state != r_cand) begin
        r_cand   <= track_state;
        r_db_cnt <= DBW'(1);
      end else if (r_db_cnt != DB_FULL) begin
        r_db_cnt <= r_db_cnt + 1'b1;
        if (r_db_cnt == DB_LAST) r_filt <= r_cand;
      end
      if (w_off_line && r_state != ST_IDLE && r_state != ST_SEARCH) begin
        if (r_lost_cnt != LOST_MAX) r_lost_cnt <= r_lost_cnt + 1'b1;
      end else begin
        r_lost_cnt <= '0;
      end
      if (w_next == ST_LEFT)  r_last_turn <= TURN_LEFT;
      if (w_next == ST_RIGHT) r_last_turn <= TURN_RIGHT;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!start_move) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_next = ST_FWD;
        ST_SEARCH: if (!w_off_line) w_next = ST_FWD;
        default: begin
          if (r_lost_cnt == LOST_MAX) begin
            w_next = ST_SEARCH;
          end else begin
            case (r_state)
              ST_STOP: if (r_filt != TRK_STOP) w_next = ST_FWD;
              default: begin
                case (r_filt)
                  TRK_STRAIGHT: w_next = ST_FWD;
                  TRK_LEFT:     w_next = ST_LEFT;
                  TRK_RIGHT:    w_next = ST_RIGHT;
                  default:      w_next = ST_STOP;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    w_l_duty = '0;
    w_r_duty = '0;
    w_l_dir  = DIR_BRK;
    w_r_dir  = DIR_BRK;
    case (r_state)
      ST_FWD: begin
        w_l_dir = DIR_FWD; w_r_dir = DIR_FWD; w_l_duty = D_FAST; w_r_duty = D_FAST;
      end
      ST_LEFT: begin
        w_l_dir = DIR_FWD; w_r_dir = DIR_FWD; w_l_duty = D_SLOW; w_r_duty = D_FAST;
      end
      ST_RIGHT: begin
        w_l_dir = DIR_FWD; w_r_dir = DIR_FWD; w_l_duty = D_FAST; w_r_duty = D_SLOW;
      end
      ST_SEARCH: begin
        w_l_duty = D_SLOW;
        w_r_duty = D_SLOW;
        w_l_dir  = (r_last_turn == TURN_LEFT) ? DIR_REV : DIR_FWD;
        w_r_dir  = (r_last_turn == TURN_LEFT) ? DIR_FWD : DIR_REV;
      end
      default: ;
    endcase
  end

  pwm_channel #(.CW(CW), .RAMP_STEP(RAMP_STEP)) u_left (
    .clk(clk), .reset(reset), .i_strobe(w_strobe), .i_kill(w_next == ST_IDLE),
    .i_target_duty(w_l_duty), .i_target_dir(w_l_dir), .i_cnt(r_cnt),
    .o_pwm(left_pwm), .o_dir(left_dir)
  );

  pwm_channel #(.CW(CW), .RAMP_STEP(RAMP_STEP)) u_right (
    .clk(clk), .reset(reset), .i_strobe(w_strobe), .i_kill(w_next == ST_IDLE),
    .i_target_duty(w_r_duty), .i_target_dir(w_r_dir), .i_cnt(r_cnt),
    .o_pwm(right_pwm), .o_dir(right_dir)
  );

  assign motion = r_state;
  assign lost   = (r_state == ST_SEARCH);

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl with small timing parameters; the
// SOFT_START_EN build runs the ramp sequence instead of the steering sequence.
module tb_motor_drive_ctrl;

  localparam int PP = 16;

  logic       clk = 1'b0;
  logic       reset, start_move;
  logic [1:0] track_state;
  logic [2:0] sensor;
  logic       left_pwm, right_pwm, lost;
  logic [1:0] left_dir, right_dir;
  logic [2:0] motion;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lh, rh;

  always #5 clk = ~clk;

  motor_drive_ctrl #(
    .PWM_PERIOD(16), .DUTY_FAST(12), .DUTY_SLOW(8),
    .DEBOUNCE(4), .LOST_TIMEOUT(32), .RAMP_STEP(4)
  ) dut (
    .clk(clk), .reset(reset), .start_move(start_move),
    .track_state(track_state), .sensor(sensor),
    .left_pwm(left_pwm), .right_pwm(right_pwm),
    .left_dir(left_dir), .right_dir(right_dir),
    .motion(motion), .lost(lost)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic wait_boundary();
    step(1);
    while (cyc % PP != 0) step(1);
  endtask

  task automatic measure(output int l_hi, output int r_hi);
    l_hi = 0;
    r_hi = 0;
    for (int i = 0; i < PP; i++) begin
      l_hi += int'(left_pwm);
      r_hi += int'(right_pwm);
      step(1);
    end
  endtask

  initial begin
    reset = 1'b1; start_move = 1'b0; track_state = 2'b11; sensor = 3'b101;
    step(3);
    chk("rst_motion", 32'(motion), 0);
    chk("rst_lpwm", 32'(left_pwm), 0);
    chk("rst_rpwm", 32'(right_pwm), 0);
    chk("rst_ldir", 32'(left_dir), 0);
    chk("rst_rdir", 32'(right_dir), 0);
    chk("rst_lost", 32'(lost), 0);

    reset = 1'b0; start_move = 1'b1; cyc = 0;
    step(1);
    chk("start_fwd", 32'(motion), 1);
    chk("pre_bound_lpwm", 32'(left_pwm), 0);

`ifdef SOFT_START_EN
    wait_boundary();
    measure(lh, rh);
    chk("ramp1_l", 32'(lh), 4);
    chk("ramp1_r", 32'(rh), 4);
    measure(lh, rh);
    chk("ramp2_l", 32'(lh), 8);
    chk("ramp2_r", 32'(rh), 8);
    measure(lh, rh);
    chk("ramp3_l", 32'(lh), 12);
    chk("ramp3_r", 32'(rh), 12);
    chk("ramp_ldir", 32'(left_dir), 2);
    step(2);
    chk("ramp_mid_lpwm", 32'(left_pwm), 1);
    reset = 1'b1;
    step(1);
    chk("ramp_rst_lpwm", 32'(left_pwm), 0);
    chk("ramp_rst_rpwm", 32'(right_pwm), 0);
    chk("ramp_rst_ldir", 32'(left_dir), 0);
    chk("ramp_rst_motion", 32'(motion), 0);
`else
    wait_boundary();
    measure(lh, rh);
    chk("fwd_l_hi", 32'(lh), 12);
    chk("fwd_r_hi", 32'(rh), 12);
    chk("fwd_ldir", 32'(left_dir), 2);
    chk("fwd_rdir", 32'(right_dir), 2);

    track_state = 2'b10; step(3);
    track_state = 2'b11; step(6);
    chk("debounce_3", 32'(motion), 1);
    track_state = 2'b10; step(4);
    chk("debounce_4_pending", 32'(motion), 1);
    step(1);
    chk("left_entry", 32'(motion), 2);
    wait_boundary();
    measure(lh, rh);
    chk("left_l_hi", 32'(lh), 8);
    chk("left_r_hi", 32'(rh), 12);

    track_state = 2'b01; step(5);
    chk("right_entry", 32'(motion), 3);
    sensor = 3'b111; step(31);
    chk("lost_31", 32'(motion), 3);
    step(1);
    chk("lost_32_motion", 32'(motion), 5);
    chk("lost_32_flag", 32'(lost), 1);
    wait_boundary();
    measure(lh, rh);
    chk("search_l_hi", 32'(lh), 8);
    chk("search_r_hi", 32'(rh), 8);
    chk("search_ldir", 32'(left_dir), 2);
    chk("search_rdir", 32'(right_dir), 1);
    track_state = 2'b11; step(5);
    sensor = 3'b110; step(1);
    chk("found_motion", 32'(motion), 1);
    chk("found_lost", 32'(lost), 0);

    track_state = 2'b00; step(5);
    chk("stop_entry", 32'(motion), 4);
    wait_boundary();
    measure(lh, rh);
    chk("stop_l_hi", 32'(lh), 0);
    chk("stop_r_hi", 32'(rh), 0);
    chk("stop_ldir", 32'(left_dir), 0);
    chk("stop_rdir", 32'(right_dir), 0);
    track_state = 2'b11; step(5);
    chk("stop_exit", 32'(motion), 1);

    wait_boundary();
    step(3);
    chk("estop_pre_lpwm", 32'(left_pwm), 1);
    start_move = 1'b0;
    step(1);
    chk("estop_lpwm", 32'(left_pwm), 0);
    chk("estop_rpwm", 32'(right_pwm), 0);
    chk("estop_ldir", 32'(left_dir), 0);
    chk("estop_rdir", 32'(right_dir), 0);
    chk("estop_motion", 32'(motion), 0);

    start_move = 1'b1;
    step(1);
    wait_boundary();
    step(2);
    chk("midrst_pre_rpwm", 32'(right_pwm), 1);
    reset = 1'b1;
    step(1);
    chk("midrst_rpwm", 32'(right_pwm), 0);
    chk("midrst_rdir", 32'(right_dir), 0);
    chk("midrst_motion", 32'(motion), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
